// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic valid/ready pipeline-stage register.
//
// Holds a WIDTH-bit payload between two pipeline stages with backpressure,
// synchronous flush (bubble insert) and a saturating backpressure counter.
//
// Build option: define PIPE_SKID_BUFFER_EN to get a two-entry (main + skid)
// stage whose in_ready is decoded from registered state only. Otherwise the
// stage is single-entry and in_ready depends combinationally on out_ready.
//
// Parameters:
//   WIDTH           payload width in bits
//   CLEAR_ON_BUBBLE 1: out_data reads 0 while out_valid=0; 0: holds last value
//   STALL_CNT_W     width of the saturating stall counter
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low
//   flush      synchronous kill of all held entries
//   in_valid   upstream payload valid
//   in_ready   stage can accept this cycle
//   in_data    upstream payload
//   out_valid  payload valid to downstream
//   out_ready  downstream accepts this cycle
//   out_data   payload to downstream
//   stall_cnt  cycles with out_valid=1 and out_ready=0 (saturating)
module pipe_stage_reg #(
    parameter int unsigned WIDTH           = 64,
    parameter int unsigned CLEAR_ON_BUBBLE = 1,
    parameter int unsigned STALL_CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

`ifdef PIPE_SKID_BUFFER_EN
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
`else
    typedef enum logic {EMPTY, FULL} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic             accept, emit;

`ifdef PIPE_SKID_BUFFER_EN
    logic [WIDTH-1:0] skid_q, skid_d;

    // in_ready is decoded from the state register only, so there is no
    // combinational path from out_ready back upstream.
    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != TWO);
`else
    assign out_valid = (state_q == FULL);
    assign in_ready  = ~out_valid | out_ready;
`endif

    assign accept = in_valid & in_ready;
    assign emit   = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
`ifdef PIPE_SKID_BUFFER_EN
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (accept && emit) begin
                        main_d = in_data;
                    end else if (accept) begin
                        // Downstream stalled: park the newcomer behind main.
                        state_d = TWO;
                        skid_d  = in_data;
                    end else if (emit) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (emit) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
`else
        if (flush) begin
            state_d = EMPTY;
        end else if (accept) begin
            state_d = FULL;
            main_d  = in_data;
        end else if (emit) begin
            state_d = EMPTY;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
`ifdef PIPE_SKID_BUFFER_EN
            skid_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
`ifdef PIPE_SKID_BUFFER_EN
            skid_q  <= skid_d;
`endif
        end
    end

    // Flush does not clear the counter; only reset does.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

    // Main register is only written on accept/skid-promote, so an X on
    // in_data during a bubble can never reach out_data.
    always_comb begin
        if ((CLEAR_ON_BUBBLE != 0) && !out_valid) begin
            out_data = '0;
        end else begin
            out_data = main_q;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: self-checking bench for pipe_stage_reg.
//
// Three instances share the same stimulus: the default configuration, one
// with a 2-bit stall counter (saturation), and one with CLEAR_ON_BUBBLE=0
// (hold-last-value). Expected values come from a queue-based model of the
// stage (capacity 1, or 2 when PIPE_SKID_BUFFER_EN is defined).
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, flush, in_valid, out_ready;
    logic [63:0] in_data;

    logic        in_ready, out_valid;
    logic [63:0] out_data;
    logic [15:0] stall_cnt;

    logic        s_in_ready, s_out_valid;
    logic [63:0] s_out_data;
    logic [1:0]  s_stall_cnt;

    logic        h_in_ready, h_out_valid;
    logic [63:0] h_out_data;
    logic [15:0] h_stall_cnt;

    pipe_stage_reg #(.WIDTH(64), .CLEAR_ON_BUBBLE(1), .STALL_CNT_W(16)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.WIDTH(64), .CLEAR_ON_BUBBLE(1), .STALL_CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .stall_cnt(s_stall_cnt)
    );

    pipe_stage_reg #(.WIDTH(64), .CLEAR_ON_BUBBLE(0), .STALL_CNT_W(16)) dut_h (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(h_in_ready), .in_data(in_data),
        .out_valid(h_out_valid), .out_ready(out_ready), .out_data(h_out_data),
        .stall_cnt(h_stall_cnt)
    );

`ifdef PIPE_SKID_BUFFER_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [63:0] q[$];
    int          stall_m = 0;
    logic [63:0] held = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic model_in_ready(input logic ordy);
        if (CAP == 2) return (q.size() < 2);
        return (q.size() == 0) || ordy;
    endfunction

    task automatic check_outs(input string tag);
        logic        ev;
        logic [63:0] ed;
        int          sat;
        ev  = (q.size() > 0);
        ed  = ev ? q[0] : 64'h0;
        sat = (stall_m > 3) ? 3 : stall_m;
        chk({tag, ".valid"},   {63'h0, out_valid},   {63'h0, ev});
        chk({tag, ".data"},    out_data,             ed);
        chk({tag, ".stall"},   {48'h0, stall_cnt},   64'(stall_m));
        chk({tag, ".s_stall"}, {62'h0, s_stall_cnt}, 64'(sat));
        chk({tag, ".h_valid"}, {63'h0, h_out_valid}, {63'h0, ev});
        chk({tag, ".h_data"},  h_out_data,           held);
    endtask

    // One clock: drive at negedge, check in_ready before the edge, advance
    // the model, check registered outputs 1 time unit after the edge.
    task automatic cycle(input logic v, input logic [63:0] d, input logic ordy,
                         input logic fl, input string tag);
        logic exp_ir, emit, acc;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        exp_ir = model_in_ready(ordy);
        chk({tag, ".in_ready"},   {63'h0, in_ready},   {63'h0, exp_ir});
        chk({tag, ".s_in_ready"}, {63'h0, s_in_ready}, {63'h0, exp_ir});
        if (!reset) begin
            q.delete();
            stall_m = 0;
            held    = '0;
        end else begin
            emit = (q.size() > 0) && ordy;
            acc  = v && exp_ir;
            if ((q.size() > 0) && !ordy) stall_m++;
            if (fl) begin
                q.delete();
            end else begin
                if (emit) void'(q.pop_front());
                if (acc)  q.push_back(d);
            end
            if (q.size() > 0) held = q[0];
        end
        @(posedge clk);
        #1;
        check_outs(tag);
    endtask

    initial begin
        int s0;
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_data   = '0;

        // Reset held low with a valid payload on the input.
        cycle(1'b1, 64'hDEAD, 1'b1, 1'b0, "t1_rst_a");
        cycle(1'b1, 64'hDEAD, 1'b1, 1'b0, "t1_rst_b");
        chk("t1_rst_data", out_data, 64'h0);
        reset = 1'b1;
        cycle(1'b1, 64'h1, 1'b1, 1'b0, "t1_first");
        chk("t1_first_data", out_data, 64'h1);

        // Back-to-back stream, one payload per cycle.
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, 64'(i), 1'b1, 1'b0, "t2_stream");
            chk("t2_stream_data", out_data, 64'(i));
        end

        // Stall with stable data and counter saturation on the 2-bit instance.
        cycle(1'b1, 64'hA5, 1'b1, 1'b0, "t3_load");
        for (int i = 0; i < 5; i++) cycle(1'b0, 64'hx, 1'b0, 1'b0, "t3_stall");
        chk("t3_hold_data", out_data, 64'hA5);
        chk("t3_stall5", {48'h0, stall_cnt}, 64'd5);
        cycle(1'b0, 64'hx, 1'b0, 1'b0, "t3_stall6");
        chk("t3_sat", {62'h0, s_stall_cnt}, 64'd3);

        // Flush in the same cycle as an accept.
        s0 = stall_m;
        cycle(1'b1, 64'h77, 1'b1, 1'b1, "t4_flush");
        chk("t4_flush_valid", {63'h0, out_valid}, 64'h0);
        chk("t4_flush_data", out_data, 64'h0);
        chk("t4_flush_stall", {48'h0, stall_cnt}, 64'(s0));
        for (int i = 0; i < 3; i++) cycle(1'b0, 64'hx, 1'b1, 1'b0, "t4_drain");

        // Two payloads into a stalled stage, then release.
        cycle(1'b1, 64'h10, 1'b0, 1'b0, "t5_a");
        cycle(1'b1, 64'h11, 1'b0, 1'b0, "t5_b");
        cycle(1'b0, 64'hx,  1'b0, 1'b0, "t5_wait");
        for (int i = 0; i < 3; i++) cycle(1'b0, 64'hx, 1'b1, 1'b0, "t5_release");

        // Asynchronous reset in the middle of a stall.
        cycle(1'b1, 64'h55, 1'b0, 1'b0, "t6_a");
        cycle(1'b1, 64'h66, 1'b0, 1'b0, "t6_b");
        cycle(1'b0, 64'hx,  1'b0, 1'b0, "t6_stall");
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        q.delete();
        stall_m = 0;
        held    = '0;
        check_outs("t6_async");
        chk("t6_async_ready", {63'h0, in_ready}, 64'h1);
        cycle(1'b1, 64'hBAD, 1'b1, 1'b0, "t6_inrst");
        reset = 1'b1;
        cycle(1'b1, 64'h123, 1'b1, 1'b0, "t6_after");
        chk("t6_after_data", out_data, 64'h123);
        cycle(1'b0, 64'hx, 1'b1, 1'b0, "t6_drain");

        // Randomized traffic; bubbles carry X payloads.
        for (int i = 0; i < 400; i++) begin
            logic        v, r, f;
            logic [63:0] d;
            v = ($urandom_range(0, 99) < 70);
            r = ($urandom_range(0, 99) < 60);
            f = ($urandom_range(0, 99) < 5);
            d = {$urandom, $urandom};
            cycle(v, v ? d : 64'hx, r, f, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
